// File: rtl/sram_responder.sv
// sram_responder: executes single-word read/write requests as timed
// transactions on an external asynchronous 16-bit SRAM.
// Sequence per request: SETUP (address/CE, write data driven), ACCESS
// (OE or WE strobe held WAIT_STATES+1 cycles), HOLD (strobe released,
// address/data still held), DONE (one-cycle ready pulse, CE released).
// Every output, including the SRAM pins, comes straight from a flop.
module sram_responder #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              cpu_we_n,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   output logic [DATA_W-1:0] ram_q,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_dq_in,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n_o
);

   // Counter must hold WAIT_STATES; keep at least one bit when it is 0.
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_we_n;   // latched transaction direction

   // Transaction FSM; all SRAM pins and CPU-side outputs are set here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we_n      <= 1'b1;
         ready       <= 1'b0;
         ram_q       <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n_o <= 1'b1;
      end else begin
         ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  // Capture the request; SETUP presents address and CE
                  // (and write data) from the next cycle on.
                  r_we_n    <= cpu_we_n;
                  sram_addr <= ram_addr;
                  sram_ce_n <= 1'b0;
                  if (!cpu_we_n) begin
                     sram_dq_out <= ram_data;
                     sram_dq_oe  <= 1'b1;
                  end
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_we_n) begin
                  sram_oe_n <= 1'b0;
               end else begin
                  sram_we_n_o <= 1'b0;
               end
               r_cnt   <= WS_LOAD;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (r_cnt == '0) begin
                  sram_oe_n   <= 1'b1;
                  sram_we_n_o <= 1'b1;
                  // Read data is sampled while OE is still asserted.
                  if (r_we_n) begin
                     ram_q <= sram_dq_in;
                  end
                  r_state <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_HOLD: begin
               ready      <= 1'b1;
               sram_ce_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               r_state    <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
